// File: rtl/row_sampler_pkg.sv
// Shared types for the row sampler: FSM state, RGB pixel layout and marker colour.
package row_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t MARK_COLOR = '{r: 8'hFF, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/row_sampler_buf.sv
// Bin-average buffer: simple dual-port RAM with a registered, enable-gated read port.
module row_sampler_buf
  import row_sampler_pkg::*;
#(
  parameter  int unsigned DEPTH = 80,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rgb_t          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output rgb_t          rd_data
);

  rgb_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when not enabled so the stream payload stays stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/row_sampler.sv
// Row sampler: 1-cycle video passthrough plus bin averaging of one scan row per frame, drained over valid/ready.
// Define ROW_SAMPLER_MARK_EN to paint passthrough pixels of the scan row red (sampling still uses data_i).
module row_sampler
  import row_sampler_pkg::*;
#(
  parameter  int unsigned H_ACTIVE = 1280,
  parameter  int unsigned V_ACTIVE = 720,
  parameter  int unsigned SCAN_ROW = 360,
  parameter  int unsigned BIN_LOG2 = 4,
  localparam int unsigned NUM_BINS = H_ACTIVE >> BIN_LOG2,
  localparam int unsigned IDX_W    = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      data_i,
  input  logic             vde_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [23:0]      data_o,
  output logic             vde_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [23:0]      bin_data_o,
  output logic [IDX_W-1:0] bin_idx_o,
  output logic             bin_valid_o,
  input  logic             bin_ready_i,
  output logic             frame_done_o,
  output logic             overrun_o
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam int unsigned AW = 8 + BIN_LOG2;
  localparam int unsigned PW = IDX_W + 1;

  state_e           state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  rgb_t             px;
  logic             vde_rise, vde_fall, vsync_rise;
  logic             in_row, row_start, cap, bin_first, bin_last;
  logic [AW-1:0]    acc_r, acc_g, acc_b;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  rgb_t             wr_data, rd_data;
  logic [PW-1:0]    ptr;
  logic             load, xfer;

  // The registered control outputs double as the previous-cycle copies for edge detection.
  assign px         = data_i;
  assign vde_rise   = vde_i & ~vde_o;
  assign vde_fall   = ~vde_i & vde_o;
  assign vsync_rise = vsync_i & ~vsync_o;
  assign in_row     = (y == YW'(SCAN_ROW));
  assign row_start  = vde_rise & in_row;
  assign cap        = vde_i & (x < XW'(H_ACTIVE)) &
                      ((state == CAPTURE) | ((state == IDLE) & row_start));
  assign bin_first  = (x[BIN_LOG2-1:0] == '0);
  assign bin_last   = &x[BIN_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= '0;
      vde_o   <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      vde_o   <= vde_i;
      hsync_o <= hsync_i;
      vsync_o <= vsync_i;
`ifdef ROW_SAMPLER_MARK_EN
      data_o  <= (vde_i && in_row) ? MARK_COLOR : data_i;
`else
      data_o  <= data_i;
`endif
    end
  end

  // Pixel position; both counters saturate so overlong lines/frames cannot alias onto the scan row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (!vde_i)                      x <= '0;
      else if (x != XW'(H_ACTIVE))     x <= x + 1'b1;
      if (vsync_rise)                  y <= '0;
      else if (vde_fall && y != YW'(V_ACTIVE)) y <= y + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      acc_g   <= '0;
      acc_b   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en <= cap & bin_last;
      if (cap) begin
        if (bin_first) begin
          acc_r <= AW'(px.r);
          acc_g <= AW'(px.g);
          acc_b <= AW'(px.b);
        end else begin
          acc_r <= acc_r + AW'(px.r);
          acc_g <= acc_g + AW'(px.g);
          acc_b <= acc_b + AW'(px.b);
        end
        if (bin_last) wr_addr <= IDX_W'(x >> BIN_LOG2);
      end
    end
  end

  // Completed bin sum is written the cycle after its last pixel.
  assign wr_data = '{r: 8'(acc_r >> BIN_LOG2),
                     g: 8'(acc_g >> BIN_LOG2),
                     b: 8'(acc_b >> BIN_LOG2)};

  // Fetch the next bin whenever the output slot is empty or being consumed this cycle.
  assign xfer = bin_valid_o & bin_ready_i;
  assign load = (state == DRAIN) & (ptr != PW'(NUM_BINS)) & (~bin_valid_o | bin_ready_i);

  row_sampler_buf #(
    .DEPTH (NUM_BINS)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_addr (IDX_W'(ptr)),
    .rd_data (rd_data)
  );

  assign bin_data_o = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      bin_valid_o  <= 1'b0;
      bin_idx_o    <= '0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
      if (load) begin
        bin_valid_o <= 1'b1;
        bin_idx_o   <= IDX_W'(ptr);
        ptr         <= ptr + 1'b1;
      end else if (xfer) begin
        bin_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (row_start) begin
            state <= CAPTURE;
            ptr   <= '0;
          end
        end
        CAPTURE: begin
          if (vde_fall) state <= DRAIN;
        end
        DRAIN: begin
          if (row_start) overrun_o <= 1'b1;
          if (xfer && ptr == PW'(NUM_BINS)) begin
            state        <= IDLE;
            frame_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_sampler.sv
// Directed bench for row_sampler: 64x8 frames, scan row 3, 4 bins of 16 pixels.
`timescale 1ns/1ps
module tb_row_sampler;

  localparam int H_ACTIVE = 64;
  localparam int V_ACTIVE = 8;
  localparam int SCAN_ROW = 3;
  localparam int BIN_LOG2 = 4;
  localparam int NUM_BINS = 4;
  localparam logic [23:0] MARK = 24'hFF0000;

  logic        clk;
  logic        rst_n;
  logic [23:0] data_i;
  logic        vde_i, hsync_i, vsync_i;
  logic [23:0] data_o;
  logic        vde_o, hsync_o, vsync_o;
  logic [23:0] bin_data_o;
  logic [1:0]  bin_idx_o;
  logic        bin_valid_o, bin_ready_i, frame_done_o, overrun_o;

  row_sampler #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .SCAN_ROW (SCAN_ROW),
    .BIN_LOG2 (BIN_LOG2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .vde_i        (vde_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .data_o       (data_o),
    .vde_o        (vde_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .bin_data_o   (bin_data_o),
    .bin_idx_o    (bin_idx_o),
    .bin_valid_o  (bin_valid_o),
    .bin_ready_i  (bin_ready_i),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  int tb_line  = -1;

  // Recorder: sampled mid-cycle, notes accepted beats, pulses, stall stability and passthrough delay.
  logic [23:0] beat_data [$];
  int          beat_idx  [$];
  int          beat_cyc  [$];
  int          mcyc = 0, done_cnt = 0, done_cyc = -1, ovr_cnt = 0, fall_cyc = -1;
  int          stall_bad = 0, pt_bad = 0, pt_cnt = 0, mark_seen = 0;
  logic        stalled = 1'b0;
  logic [23:0] st_data = '0;
  logic [1:0]  st_idx = '0;
  logic        p_rst = 1'b0, p_vde = 1'b0, p_hs = 1'b0, p_vs = 1'b0;
  logic [23:0] p_data = '0;
  int          p_line = -1;

  always @(negedge clk) begin
    logic [23:0] exp_d;
    mcyc++;
    if (rst_n && p_rst) begin
      exp_d = p_data;
`ifdef ROW_SAMPLER_MARK_EN
      if (p_vde && p_line == SCAN_ROW) exp_d = MARK;
`endif
      pt_cnt++;
      if (data_o !== exp_d || vde_o !== p_vde || hsync_o !== p_hs || vsync_o !== p_vs) pt_bad++;
      if (p_vde && p_line == SCAN_ROW && data_o === MARK) mark_seen++;
    end
    if (rst_n && stalled &&
        (bin_valid_o !== 1'b1 || bin_data_o !== st_data || bin_idx_o !== st_idx)) stall_bad++;
    stalled = rst_n && bin_valid_o && !bin_ready_i;
    st_data = bin_data_o;
    st_idx  = bin_idx_o;
    if (rst_n && bin_valid_o && bin_ready_i) begin
      beat_data.push_back(bin_data_o);
      beat_idx.push_back(int'(bin_idx_o));
      beat_cyc.push_back(mcyc);
    end
    if (frame_done_o) begin
      done_cnt++;
      done_cyc = mcyc;
    end
    if (overrun_o) ovr_cnt++;
    if (p_vde && !vde_i && tb_line == SCAN_ROW) fall_cyc = mcyc;
    p_rst  = rst_n;
    p_vde  = vde_i;
    p_hs   = hsync_i;
    p_vs   = vsync_i;
    p_data = data_i;
    p_line = tb_line;
  end

  function automatic logic [23:0] pix(input int pat, input int line, input int x);
    logic [7:0] r, g, b;
    if (pat == 0) return 24'h102030;
    if (line != SCAN_ROW) return 24'hABCDEF;
    if (pat == 1) begin
      r = 8'(x);
      g = 8'(255 - x);
      b = 8'h00;
    end else begin
      r = 8'(32 * (x / 16) + x % 16);
      g = 8'hA5;
      b = 8'(x / 16);
    end
    return {r, g, b};
  endfunction

  // Hand-computed bin averages. Ramp: R=x averages to 16k+7; G=255-x averages to 247.5-16k, truncated 247-16k.
  function automatic logic [23:0] exp_bin(input int pat, input int k);
    if (pat == 0) return 24'h102030;
    if (pat == 1) begin
      case (k)
        0:       return 24'h07F700;
        1:       return 24'h17E700;
        2:       return 24'h27D700;
        default: return 24'h37C700;
      endcase
    end
    case (k)
      0:       return 24'h07A500;
      1:       return 24'h27A501;
      2:       return 24'h47A502;
      default: return 24'h67A503;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       bin_ready_i = 1'b1;
      1:       bin_ready_i = (cyc % 3 == 0);
      default: bin_ready_i = 1'b0;
    endcase
  endtask

  task automatic drive(input logic vde, input logic hs, input logic vs, input logic [23:0] d,
                       input int line);
    vde_i   = vde;
    hsync_i = hs;
    vsync_i = vs;
    data_i  = d;
    tb_line = line;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h000000, -1);
  endtask

  task automatic send_frame(input int pat, input int stop_row, input int stop_x);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, (i < 2), 24'h123456, -1);
    for (int ln = 0; ln < V_ACTIVE; ln++) begin
      for (int x = 0; x < H_ACTIVE; x++) begin
        if (ln == stop_row && x == stop_x) return;
        drive(1'b1, 1'b0, 1'b0, pix(pat, ln, x), ln);
      end
      for (int i = 0; i < 8; i++) drive(1'b0, (i >= 2 && i < 4), 1'b0, 24'h0F0F0F ^ 24'(i), ln);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy_mode = 0;
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF, -1);
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF, -1);
    checks++; if (data_o !== 24'h0)      begin failures++; $display("FAIL reset_data_o got=%h exp=0", data_o); end
    checks++; if (vde_o !== 1'b0)        begin failures++; $display("FAIL reset_vde_o got=%b exp=0", vde_o); end
    checks++; if (hsync_o !== 1'b0)      begin failures++; $display("FAIL reset_hsync_o got=%b exp=0", hsync_o); end
    checks++; if (vsync_o !== 1'b0)      begin failures++; $display("FAIL reset_vsync_o got=%b exp=0", vsync_o); end
    checks++; if (bin_data_o !== 24'h0)  begin failures++; $display("FAIL reset_bin_data got=%h exp=0", bin_data_o); end
    checks++; if (bin_idx_o !== 2'd0)    begin failures++; $display("FAIL reset_bin_idx got=%0d exp=0", bin_idx_o); end
    checks++; if (bin_valid_o !== 1'b0)  begin failures++; $display("FAIL reset_bin_valid got=%b exp=0", bin_valid_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_o); end
    checks++; if (overrun_o !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
    idle(2);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_constant();
    int b0, d0, o0;
    b0 = beat_data.size(); d0 = done_cnt; o0 = ovr_cnt;
    rdy_mode = 0;
    send_frame(0, -1, -1);
    idle(30);
    checks++;
    if (beat_data.size() - b0 !== NUM_BINS) begin
      failures++; $display("FAIL const_beat_count got=%0d exp=%0d", beat_data.size() - b0, NUM_BINS);
    end else begin
      for (int k = 0; k < NUM_BINS; k++) begin
        checks++; if (beat_idx[b0+k] !== k) begin failures++; $display("FAIL const_idx%0d got=%0d exp=%0d", k, beat_idx[b0+k], k); end
        checks++; if (beat_data[b0+k] !== exp_bin(0, k)) begin failures++; $display("FAIL const_data%0d got=%h exp=%h", k, beat_data[b0+k], exp_bin(0, k)); end
        checks++; if (beat_cyc[b0+k] !== beat_cyc[b0] + k) begin failures++; $display("FAIL const_b2b%0d got=%0d exp=%0d", k, beat_cyc[b0+k], beat_cyc[b0] + k); end
      end
      checks++; if (done_cyc !== beat_cyc[b0+3] + 1) begin failures++; $display("FAIL const_done_timing got=%0d exp=%0d", done_cyc, beat_cyc[b0+3] + 1); end
      checks++; if (beat_cyc[b0] > fall_cyc + 3) begin failures++; $display("FAIL const_first_latency got=%0d exp<=%0d", beat_cyc[b0], fall_cyc + 3); end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL const_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (ovr_cnt - o0 !== 0)  begin failures++; $display("FAIL const_overrun got=%0d exp=0", ovr_cnt - o0); end
  endtask

  task automatic test_ramp();
    int b0, d0;
    b0 = beat_data.size(); d0 = done_cnt;
    rdy_mode = 0;
    send_frame(1, -1, -1);
    idle(30);
    checks++;
    if (beat_data.size() - b0 !== NUM_BINS) begin
      failures++; $display("FAIL ramp_beat_count got=%0d exp=%0d", beat_data.size() - b0, NUM_BINS);
    end else begin
      for (int k = 0; k < NUM_BINS; k++) begin
        checks++; if (beat_idx[b0+k] !== k) begin failures++; $display("FAIL ramp_idx%0d got=%0d exp=%0d", k, beat_idx[b0+k], k); end
        checks++; if (beat_data[b0+k] !== exp_bin(1, k)) begin failures++; $display("FAIL ramp_data%0d got=%h exp=%h", k, beat_data[b0+k], exp_bin(1, k)); end
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ramp_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int b0, d0, s0;
    b0 = beat_data.size(); d0 = done_cnt; s0 = stall_bad;
    rdy_mode = 1;
    send_frame(2, -1, -1);
    idle(30);
    rdy_mode = 0;
    idle(2);
    checks++;
    if (beat_data.size() - b0 !== NUM_BINS) begin
      failures++; $display("FAIL stall_beat_count got=%0d exp=%0d", beat_data.size() - b0, NUM_BINS);
    end else begin
      for (int k = 0; k < NUM_BINS; k++) begin
        checks++; if (beat_idx[b0+k] !== k) begin failures++; $display("FAIL stall_idx%0d got=%0d exp=%0d", k, beat_idx[b0+k], k); end
        checks++; if (beat_data[b0+k] !== exp_bin(2, k)) begin failures++; $display("FAIL stall_data%0d got=%h exp=%h", k, beat_data[b0+k], exp_bin(2, k)); end
      end
    end
    checks++; if (stall_bad - s0 !== 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", stall_bad - s0); end
    checks++; if (done_cnt - d0 !== 1)  begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    int b0, d0, o0, s0;
    b0 = beat_data.size(); d0 = done_cnt; o0 = ovr_cnt; s0 = stall_bad;
    rdy_mode = 2;
    send_frame(2, -1, -1);
    send_frame(1, -1, -1);
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr_pulse_count got=%0d exp=1", ovr_cnt - o0); end
    checks++; if (beat_data.size() - b0 !== 0) begin failures++; $display("FAIL ovr_early_beats got=%0d exp=0", beat_data.size() - b0); end
    rdy_mode = 0;
    idle(30);
    checks++;
    if (beat_data.size() - b0 !== NUM_BINS) begin
      failures++; $display("FAIL ovr_beat_count got=%0d exp=%0d", beat_data.size() - b0, NUM_BINS);
    end else begin
      for (int k = 0; k < NUM_BINS; k++) begin
        checks++; if (beat_idx[b0+k] !== k) begin failures++; $display("FAIL ovr_idx%0d got=%0d exp=%0d", k, beat_idx[b0+k], k); end
        checks++; if (beat_data[b0+k] !== exp_bin(2, k)) begin failures++; $display("FAIL ovr_data%0d got=%h exp=%h", k, beat_data[b0+k], exp_bin(2, k)); end
      end
    end
    checks++; if (done_cnt - d0 !== 1)  begin failures++; $display("FAIL ovr_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (ovr_cnt - o0 !== 1)   begin failures++; $display("FAIL ovr_total got=%0d exp=1", ovr_cnt - o0); end
    checks++; if (stall_bad - s0 !== 0) begin failures++; $display("FAIL ovr_stability got=%0d exp=0", stall_bad - s0); end
  endtask

  task automatic test_reset_mid_capture();
    int b0, d0;
    rdy_mode = 0;
    send_frame(1, SCAN_ROW, 30);
    tb_line = -1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h000000, -1);
    checks++; if (data_o !== 24'h0)      begin failures++; $display("FAIL midrst_data_o got=%h exp=0", data_o); end
    checks++; if (vde_o !== 1'b0)        begin failures++; $display("FAIL midrst_vde_o got=%b exp=0", vde_o); end
    checks++; if (bin_valid_o !== 1'b0)  begin failures++; $display("FAIL midrst_bin_valid got=%b exp=0", bin_valid_o); end
    checks++; if (bin_data_o !== 24'h0)  begin failures++; $display("FAIL midrst_bin_data got=%h exp=0", bin_data_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL midrst_frame_done got=%b exp=0", frame_done_o); end
    checks++; if (overrun_o !== 1'b0)    begin failures++; $display("FAIL midrst_overrun got=%b exp=0", overrun_o); end
    idle(2);
    rst_n = 1'b1;
    idle(4);
    b0 = beat_data.size(); d0 = done_cnt;
    checks++; if (bin_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_idle_valid got=%b exp=0", bin_valid_o); end
    send_frame(2, -1, -1);
    idle(30);
    checks++;
    if (beat_data.size() - b0 !== NUM_BINS) begin
      failures++; $display("FAIL midrst_beat_count got=%0d exp=%0d", beat_data.size() - b0, NUM_BINS);
    end else begin
      for (int k = 0; k < NUM_BINS; k++) begin
        checks++; if (beat_idx[b0+k] !== k) begin failures++; $display("FAIL midrst_idx%0d got=%0d exp=%0d", k, beat_idx[b0+k], k); end
        checks++; if (beat_data[b0+k] !== exp_bin(2, k)) begin failures++; $display("FAIL midrst_data%0d got=%h exp=%h", k, beat_data[b0+k], exp_bin(2, k)); end
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL midrst_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_passthrough();
    logic exp_marked;
`ifdef ROW_SAMPLER_MARK_EN
    exp_marked = 1'b1;
`else
    exp_marked = 1'b0;
`endif
    checks++; if (pt_bad !== 0) begin failures++; $display("FAIL passthrough_delay got=%0d bad cycles exp=0", pt_bad); end
    checks++; if (pt_cnt < 2000) begin failures++; $display("FAIL passthrough_coverage got=%0d exp>=2000", pt_cnt); end
    checks++;
    if ((mark_seen > 0) !== exp_marked) begin
      failures++; $display("FAIL passthrough_marker got=%0d marked pixels exp_any=%b", mark_seen, exp_marked);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    data_i      = '0;
    vde_i       = 1'b0;
    hsync_i     = 1'b0;
    vsync_i     = 1'b0;
    bin_ready_i = 1'b1;
    test_reset();
    test_constant();
    test_ramp();
    test_stall();
    test_overrun();
    test_reset_mid_capture();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
